uart_tx_fifo: RTL
=================

# uart_tx_fifo

Transmit-side byte buffer that sits directly upstream of `uart_top` in the UART datapath. It accepts bytes from the host side at full clock rate and stores each with a per-byte error-inject flag. It presents them to `uart_top` over its `tx_valid`/`tx_data`/`tx_error`/`tx_ready` handshake, so back-to-back frames go out without the host pacing itself to the baud rate. It also provides occupancy status and a sticky overflow flag.

## Interface
- `DATA_WIDTH`, 8, byte width; must match `uart_top`.
- `DEPTH`, 16, number of entries; power of two, ≥ 2. `AW` = $clog2(DEPTH).

Ports:
- `clk_576KHz`  in  1  system clock (same clock as `uart_top`).
- `rst_n`  in  1  reset, asynchronous, active-low.
- `wr_valid`  in  1  host offers a byte.
- `wr_data`  in  DATA_WIDTH  host byte.
- `wr_err`  in  1  request error injection for this byte; forwarded as `tx_error`.
- `wr_ready`  out  1  FIFO can accept a byte; equals !`full`.
- `flush`  in  1  synchronous clear of contents and `overflow`.
- `ovf_clr`  in  1  synchronous clear of `overflow` only.
- `tx_valid`  out  1  head entry available; drives `uart_top.tx_valid`.
- `tx_data`  out  DATA_WIDTH  head byte; drives `uart_top.tx_data`.
- `tx_error`  out  1  head error flag; drives `uart_top.tx_error`.
- `tx_ready`  in  1  from `uart_top.tx_ready`; pop when high with `tx_valid`.
- `count`  out  AW+1  entries held, 0..DEPTH.
- `full`  out  1  `count` == DEPTH.
- `empty`  out  1  `count` == 0.
- `overflow`  out  1  sticky: a write was attempted while full.

## Operation
- Storage: DEPTH × (DATA_WIDTH+1) array holding {err, data}. It is not reset.
- Pointers: `wr_ptr` and `rd_ptr` are AW+1 bits and wrap naturally modulo 2^(AW+1).
  - Array index = low AW bits.
  - `empty` = pointers equal.
  - `full` = MSBs differ and low AW bits equal.
  - `count` = `wr_ptr` − `rd_ptr` (AW+1-bit modular subtract).
- Push: occurs when `wr_valid` && !`full`. Writes {`wr_err`,`wr_data`} at `wr_ptr` and increments `wr_ptr`.
- Pop: occurs when `tx_valid` && `tx_ready`. Increments `rd_ptr`.
- Simultaneous push and pop, not full and not empty: both are performed and `count` is unchanged.
- Push while full is rejected and data is dropped, even if a pop occurs in the same cycle (no bypass). `overflow` is set on the next edge.
- Push while empty: no pop is possible that cycle because `tx_valid` is low. No combinational input-to-output bypass.
- Head output is first-word-fall-through:
  - When !`empty`: `tx_valid` = 1 and {`tx_error`,`tx_data`} = array[`rd_ptr`].
  - When `empty`: `tx_data` = 0 and `tx_error` = 0.
- Head stability: the head slot is never written while !`empty`, so `tx_data`/`tx_error` stay stable while `tx_valid` is high and `tx_ready` is low.
- `flush` has the highest priority.
  - On the next edge: both pointers → 0 and `overflow` → 0.
  - Any push or pop in the same cycle is ignored.
  - A byte already accepted by `uart_top` continues transmitting; it is not aborted.
- `overflow` priority:
  - `flush` or `ovf_clr` clears it.
  - Clear wins over a same-cycle set.
  - Otherwise it is set by a rejected push and holds.

## Timing
- Reset (async assert, sync to design via `rst_n` deassert) drives:
  - `wr_ptr` = `rd_ptr` = 0.
  - `tx_valid` = 0, `tx_data` = 0, `tx_error` = 0.
  - `count` = 0, `full` = 0, `empty` = 1, `wr_ready` = 1, `overflow` = 0.
- Reset asserted mid-operation discards all contents immediately.
- Write-to-output latency: a byte pushed on edge N is visible on `tx_valid`/`tx_data` after edge N (1 cycle).
- Status timing:
  - `count`, `full`, `empty`, `wr_ready` are registered-pointer derived and update after the edge that changes the pointers.
  - `wr_ready` has no combinational path from `tx_ready`.
- Throughput: one push and one pop per cycle sustained.

## Test plan
- Reset, then push 0xA5 (err=0) with `tx_ready`=0 → `tx_valid`=1, `tx_data`=0xA5, `count`=1 one cycle later. Hold 5 cycles: data stable. Raise `tx_ready` 1 cycle → `empty`=1, `tx_data`=0.
- Push DEPTH=16 bytes 0x00..0x0F with no pops → `full`=1, `wr_ready`=0, `count`=16. Push 0xFF → `overflow`=1, `count` stays 16. Pop all 16 → order 0x00..0x0F, 0xFF never appears.
- Fill 8 entries, then push and pop every cycle for 40 cycles (pointer wrap) → `count` constant 8, output sequence equals input sequence.
- Full FIFO, simultaneous push and pop → pop occurs, push rejected, `count`=15, `overflow`=1. Next cycle `ovf_clr` with a rejected push → `overflow`=0.
- 5 entries, assert `flush` together with a push → next cycle `count`=0, `empty`=1, `overflow`=0, pushed byte absent.
- Loopback with `uart_top` (brg_select=0): push 0xA5 (err=0), 0xFC (err=1) → `uart_top` receives 0xA5 with `rx_error`=0, then a frame with `rx_error`=1.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: transmit byte buffer feeding uart_top.
// Ports: host write side (wr_*, flush, ovf_clr), uart_top head (tx_*), status.
module uart_tx_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                  clk_576KHz,
  input  logic                  rst_n,
  input  logic                  wr_valid,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_err,
  output logic                  wr_ready,
  input  logic                  flush,
  input  logic                  ovf_clr,
  output logic                  tx_valid,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_error,
  input  logic                  tx_ready,
  output logic [AW:0]           count,
  output logic                  full,
  output logic                  empty,
  output logic                  overflow
);

  logic [DATA_WIDTH:0] mem [DEPTH];
  logic [AW:0]         wr_ptr;
  logic [AW:0]         rd_ptr;
  logic                push;
  logic                pop;
  logic [DATA_WIDTH:0] head;

  // Status comes only from the registered pointers, so wr_ready never
  // sees tx_ready combinationally and a full FIFO rejects even on a pop.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) &&
                    (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count    = wr_ptr - rd_ptr;
  assign wr_ready = !full;

  assign push = wr_valid && !full && !flush;
  assign pop  = tx_valid && tx_ready && !flush;

  assign head     = mem[rd_ptr[AW-1:0]];
  assign tx_valid = !empty;
  assign tx_data  = empty ? '0 : head[DATA_WIDTH-1:0];
  assign tx_error = empty ? 1'b0 : head[DATA_WIDTH];

  // Storage is intentionally not reset; empty gates the head outputs.
  always_ff @(posedge clk_576KHz) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= {wr_err, wr_data};
    end
  end

  always_ff @(posedge clk_576KHz or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Clear beats a same-cycle rejected push.
  always_ff @(posedge clk_576KHz or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (flush || ovf_clr) begin
      overflow <= 1'b0;
    end else if (wr_valid && full) begin
      overflow <= 1'b1;
    end
  end

endmodule
